pwm_compare_unit: RTL and testbench
===================================

Name: pwm_compare_unit

Overview:
- Downstream consumer of the free-running 5-bit counter's `count`.
- Compares the count against a programmable duty value to generate a glitch-free PWM output, a compare-match pulse and a period pulse.
- New duty/enable settings enter through a valid/ready handshake into a pending register. They are applied only at a period boundary.
- A saturating period counter reports how many full periods have run.

Parameters:
- WIDTH, 5, width of count_in and cfg_duty; must equal the upstream counter width.
- PCNT_W, 8, width of the saturating period counter.
- POLARITY, 1, 1 = pwm_out active-high; 0 = pwm_out inverted while in RUN (forced 0 outside RUN either way).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset asserted).
- count_in  in  WIDTH  count from the upstream counter, sampled every cycle.
- cfg_valid  in  1  config offer.
- cfg_ready  out  1  config accept; transfer occurs when cfg_valid && cfg_ready on a rising edge.
- cfg_duty  in  WIDTH  requested duty (high cycles per 2^WIDTH-cycle period).
- cfg_en  in  1  requested enable.
- pwm_out  out  1  PWM output, registered.
- match_pulse  out  1  one-cycle pulse when count_in equals the active duty in RUN, registered.
- period_pulse  out  1  one-cycle pulse on each period boundary, registered.
- active  out  1  high while in RUN.
- period_cnt  out  PCNT_W  completed periods in RUN; saturates at all-ones.

Behaviour:
- Reset (rst=0, asynchronous): clears everything immediately.
  - state=IDLE; count_prev=0; duty_act=0.
  - pend_full=0; pend_duty=0; pend_en=0.
  - pwm_out=0, match_pulse=0, period_pulse=0, active=0, period_cnt=0, cfg_ready=0.
  - Deassertion is taken synchronously by the design (2-flop reset synchroniser internal).
  - cfg_ready rises on the first clock edge after deassertion.
- count_prev: registers count_in every cycle.
- Boundary: boundary = (count_in == 0) && (count_prev != 0).
  - Covers the normal 31->0 wrap and an upstream mid-period reset to 0.
  - A count held at 0 produces no repeated boundary.
- Handshake:
  - cfg_ready = !pend_full.
  - On transfer, latch pend_duty/pend_en and set pend_full.
  - cfg_valid may drop without a transfer; no data is captured.
  - cfg_duty/cfg_en are ignored unless cfg_ready=1.
- Apply: on a boundary with pend_full=1, duty_act<=pend_duty and pend_full<=0, so cfg_ready is high next cycle.
- Transfer in the same cycle as a boundary (pend_full was 0): data goes to pending and applies at the next boundary, not this one.
- FSM:
  - IDLE: no active config.
    - Boundary with pend_full && pend_en -> RUN.
    - Boundary with pend_full && !pend_en -> stays IDLE; pending is consumed.
  - RUN: active.
    - Boundary with pend_full && !pend_en -> IDLE.
    - Boundary with pend_full && pend_en -> RUN with the new duty.
    - Boundary without pending -> RUN unchanged.
- Outputs: all registered, 1-cycle latency from count_in.
  - RUN on the next edge: raw = (count_in < duty_act); pwm_out = POLARITY ? raw : !raw.
    - The comparison uses duty_act as updated in that same cycle, so a new duty takes effect from count 0 of the new period.
  - IDLE: pwm_out=0.
  - match_pulse: 1 for one cycle when in RUN && count_in == duty_act && duty_act != 0.
  - period_pulse: 1 for one cycle on every boundary, in any state.
  - active = (state == RUN), registered with the state.
- period_cnt:
  - Increments on each boundary where the state is RUN before and after the boundary.
  - Holds at 2^PCNT_W-1.
  - Clears to 0 on the RUN->IDLE transition and on IDLE->RUN entry.
- Duty extremes:
  - duty 0 in RUN: pwm_out constantly inactive; no match_pulse.
  - duty 31: active for 31 of 32 cycles (counts 0..30).
- Upstream reset mid-period (count_in jumps to 0): treated as a boundary; pending config is applied, period_cnt increments.
- Asynchronous rst mid-operation: discards pending config and the current duty; the block returns to IDLE.

Test Plan:
- Reset and first config:
  - Assert rst=0 mid-cycle -> all outputs 0 immediately.
  - Release rst, count wrapping 0..31 -> cfg_ready=1 within 1 edge; no period_pulse until the first 31->0.
- Basic PWM, POLARITY=1:
  - Offer duty=10, en=1 during count=5.
  - Transfer then cfg_ready=0.
  - At the wrap -> RUN; cfg_ready=1 one cycle later.
  - Each period: pwm_out high 10 cycles (count 0..9, seen one cycle late); match_pulse once (count=10); period_pulse once per 32 cycles.
- Duty change at boundary:
  - In RUN with duty 10, offer duty=20 mid-period -> the current period stays 10 high.
  - The next period is 20 high with no partial pulse.
  - A second offer before the wrap is stalled (cfg_ready=0) until the cycle after the wrap.
- Transfer coincident with boundary: pend_full=0, cfg_valid high on the count_in=0 cycle with duty=5 -> the old duty holds for that period; 5 applies at the following wrap.
- Disable and extremes:
  - duty=0 -> pwm_out low, no match_pulse.
  - duty=31 -> 31 high, 1 low.
  - en=0 config -> IDLE at the wrap; pwm_out=0, active=0, period_cnt=0.
- Saturation and upstream reset:
  - PCNT_W=2, run 5 periods -> period_cnt reads 3 and holds.
  - Force count_in from 17 to 0 -> period_pulse fires; pending config is applied.
  - Hold count_in at 0 for 10 cycles -> no further pulses.

Source files
------------

// File: rtl/pwm_compare_unit.sv
// PWM compare stage fed by a free-running counter: duty/enable arrive through
// a valid/ready pending slot and take effect only at a period boundary.
module pwm_compare_unit #(
  parameter int WIDTH    = 5,
  parameter int PCNT_W   = 8,
  parameter bit POLARITY = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  count_in,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [WIDTH-1:0]  cfg_duty,
  input  logic              cfg_en,
  output logic              pwm_out,
  output logic              match_pulse,
  output logic              period_pulse,
  output logic              active,
  output logic [PCNT_W-1:0] period_cnt
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state, state_next;
  logic [1:0]          rst_sync;
  logic [WIDTH-1:0]    count_prev;
  logic [WIDTH-1:0]    duty_act, duty_next;
  logic [WIDTH-1:0]    pend_duty;
  logic                pend_full, pend_en;
  logic                boundary, xfer, apply, raw;
  logic                pwm_next, match_next;
  logic [PCNT_W-1:0]   pcnt_next;

  // Reset asserts immediately; release ripples through two stages so the
  // handshake wakes one edge after release and boundary detection one later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync <= '0;
    else      rst_sync <= {rst_sync[0], 1'b1};
  end

  assign cfg_ready = !pend_full && rst_sync[0];
  assign xfer      = cfg_valid && cfg_ready;
  assign boundary  = rst_sync[1] && (count_in == '0) && (count_prev != '0);
  assign apply     = boundary && pend_full;

  always_comb begin
    state_next = state;
    duty_next  = duty_act;
    pcnt_next  = period_cnt;
    pwm_next   = 1'b0;
    match_next = 1'b0;
    raw        = 1'b0;
    if (apply) begin
      duty_next  = pend_duty;
      state_next = pend_en ? RUN : IDLE;
    end
    if (boundary) begin
      if (state == RUN && state_next == RUN) begin
        if (period_cnt != '1) pcnt_next = period_cnt + 1'b1;
      end else if (state != state_next) begin
        pcnt_next = '0;
      end
    end
    // Compare against the duty that is active after this edge, so a new
    // duty governs count 0 of its own period.
    if (state_next == RUN) begin
      raw        = (count_in < duty_next);
      pwm_next   = POLARITY ? raw : !raw;
      match_next = (count_in == duty_next) && (duty_next != '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      count_prev   <= '0;
      duty_act     <= '0;
      pend_full    <= 1'b0;
      pend_duty    <= '0;
      pend_en      <= 1'b0;
      pwm_out      <= 1'b0;
      match_pulse  <= 1'b0;
      period_pulse <= 1'b0;
      active       <= 1'b0;
      period_cnt   <= '0;
    end else begin
      state        <= state_next;
      duty_act     <= duty_next;
      period_cnt   <= pcnt_next;
      pwm_out      <= pwm_next;
      match_pulse  <= match_next;
      period_pulse <= boundary;
      active       <= (state_next == RUN);
      if (rst_sync[0]) count_prev <= count_in;
      if (xfer) begin
        pend_full <= 1'b1;
        pend_duty <= cfg_duty;
        pend_en   <= cfg_en;
      end else if (apply) begin
        pend_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pwm_compare_unit.sv
// Directed bench for pwm_compare_unit: a period-level behavioural model checked
// every cycle against two instances (default, and PCNT_W=2 with inverted output).
module tb_pwm_compare_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] count_in = '0;
  logic       cfg_valid = 1'b0;
  logic [4:0] cfg_duty = '0;
  logic       cfg_en = 1'b0;

  logic       cfg_ready, pwm_out, match_pulse, period_pulse, active;
  logic [7:0] period_cnt;
  logic       cfg_ready2, pwm_out2, match_pulse2, period_pulse2, active2;
  logic [1:0] period_cnt2;

  int errors = 0;
  int checks = 0;
  bit hold = 1'b0;
  int last_xfer = 0;

  pwm_compare_unit #(.WIDTH(5), .PCNT_W(8), .POLARITY(1'b1)) dut (
    .clk(clk), .rst(rst), .count_in(count_in),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_duty(cfg_duty), .cfg_en(cfg_en),
    .pwm_out(pwm_out), .match_pulse(match_pulse), .period_pulse(period_pulse),
    .active(active), .period_cnt(period_cnt));

  pwm_compare_unit #(.WIDTH(5), .PCNT_W(2), .POLARITY(1'b0)) dut2 (
    .clk(clk), .rst(rst), .count_in(count_in),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready2), .cfg_duty(cfg_duty), .cfg_en(cfg_en),
    .pwm_out(pwm_out2), .match_pulse(match_pulse2), .period_pulse(period_pulse2),
    .active(active2), .period_cnt(period_cnt2));

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: edges since release, pending slot, run flag, duty, periods.
  int m_e = 0, m_prev = 0, m_duty = 0, m_pduty = 0, m_pcnt = 0;
  bit m_run = 0, m_pend = 0, m_pen = 0;
  bit x_pwm = 0, x_match = 0, x_pp = 0;

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_e = 0; m_prev = 0; m_duty = 0; m_pduty = 0; m_pcnt = 0;
      m_run = 0; m_pend = 0; m_pen = 0;
      x_pwm = 0; x_match = 0; x_pp = 0;
    end else begin
      bit hs, bl, bnd, was, pend_before;
      int c;
      c = int'(count_in);
      hs = (m_e >= 1);
      bl = (m_e >= 2);
      if (m_e < 3) m_e++;
      pend_before = m_pend;
      bnd = bl && (c == 0) && (m_prev != 0);
      if (bnd) begin
        if (m_pend) begin
          was = m_run;
          m_run = m_pen;
          m_duty = m_pduty;
          m_pend = 0;
          if (was && m_run) m_pcnt++;
          else if (was != m_run) m_pcnt = 0;
        end else if (m_run) begin
          m_pcnt++;
        end
      end
      if (hs && cfg_valid && !pend_before) begin
        m_pend = 1; m_pduty = int'(cfg_duty); m_pen = cfg_en;
      end
      if (hs) m_prev = c;
      x_pp = bnd;
      x_pwm = m_run && (c < m_duty);
      x_match = m_run && (c == m_duty) && (m_duty != 0);
    end
  end

  initial forever begin
    @(negedge clk);
    check("ready",   cfg_ready,    int'(!m_pend && m_e >= 1));
    check("pwm",     pwm_out,      x_pwm);
    check("match",   match_pulse,  x_match);
    check("ppulse",  period_pulse, x_pp);
    check("active",  active,       m_run);
    check("pcnt",    period_cnt,   (m_pcnt > 255) ? 255 : m_pcnt);
    check("ready2",  cfg_ready2,   int'(!m_pend && m_e >= 1));
    check("pwm2",    pwm_out2,     int'(m_run && !x_pwm));
    check("match2",  match_pulse2, x_match);
    check("ppulse2", period_pulse2, x_pp);
    check("active2", active2,      m_run);
    check("pcnt2",   period_cnt2,  (m_pcnt > 3) ? 3 : m_pcnt);
  end

  task automatic tick();
    @(negedge clk);
    if (!hold) count_in = count_in + 5'd1;
  endtask

  task automatic goto(input int v);
    int b = 0;
    while (int'(count_in) != v && b < 100) begin tick(); b++; end
    check("goto_reached", int'(count_in), v);
  endtask

  task automatic offer(input int d, input bit en);
    bit took = 0;
    int b = 0;
    cfg_valid = 1'b1; cfg_duty = 5'(d); cfg_en = en;
    while (!took && b < 100) begin
      took = cfg_ready;
      last_xfer = int'(count_in);
      tick();
      b++;
    end
    cfg_valid = 1'b0;
    check("offer_accepted", took, 1);
    $display("xfer duty=%0d en=%0d at count=%0d", d, en, last_xfer);
  endtask

  task automatic measure(input string name, input int n, input int ehi, input int emt, input int epp);
    int hi = 0, mt = 0, pp = 0;
    repeat (n) begin
      tick();
      hi += pwm_out; mt += match_pulse; pp += period_pulse;
    end
    check({name, "_high"}, hi, ehi);
    check({name, "_match"}, mt, emt);
    check({name, "_pulse"}, pp, epp);
    $display("window %s cycles=%0d high=%0d match=%0d pulse=%0d", name, n, hi, mt, pp);
  endtask

  task automatic check_zero(input string name);
    check({name, "_pwm"}, pwm_out, 0);
    check({name, "_match"}, match_pulse, 0);
    check({name, "_pp"}, period_pulse, 0);
    check({name, "_active"}, active, 0);
    check({name, "_pcnt"}, period_cnt, 0);
    check({name, "_ready"}, cfg_ready, 0);
  endtask

  initial begin
    #1 check_zero("por");
    repeat (3) tick();
    #2 rst = 1'b1;
    tick();
    check("ready_after_release", cfg_ready, 1);
    // Basic PWM at duty 10
    goto(5);
    offer(10, 1'b1);
    check("ready_low_pending", cfg_ready, 0);
    goto(0);
    tick();
    check("enter_active", active, 1);
    check("enter_ready", cfg_ready, 1);
    check("enter_pwm", pwm_out, 1);
    check("enter_pp", period_pulse, 1);
    measure("d10_rest", 31, 9, 1, 0);
    // Duty change with a second stalled offer
    goto(5);
    offer(20, 1'b1);
    goto(20);
    cfg_valid = 1'b1; cfg_duty = 5'd7; cfg_en = 1'b1;
    check("stall_mid", cfg_ready, 0);
    goto(0);
    check("stall_wrap", cfg_ready, 0);
    offer(7, 1'b1);
    check("stall_xfer_count", last_xfer, 1);
    goto(0);
    measure("d7", 32, 7, 1, 1);
    // Transfers coincident with the boundary apply one period later
    offer(5, 1'b1);
    measure("d7_tail", 31, 6, 1, 0);
    measure("d5", 32, 5, 1, 1);
    offer(0, 1'b1);
    measure("d5_tail", 31, 4, 1, 0);
    measure("d0", 32, 0, 0, 1);
    offer(31, 1'b1);
    measure("d0_tail", 31, 0, 0, 0);
    measure("d31", 32, 31, 1, 1);
    check("pcnt2_saturated", period_cnt2, 3);
    // Upstream reset to 0 mid-period, then held at 0
    goto(10);
    offer(12, 1'b1);
    goto(17);
    hold = 1'b1;
    tick();
    count_in = 5'd0;
    measure("held0", 11, 11, 0, 1);
    hold = 1'b0;
    measure("d12", 32, 12, 1, 0);
    // Disable
    offer(3, 1'b0);
    measure("d12_tail", 31, 11, 1, 0);
    tick();
    check("dis_active", active, 0);
    check("dis_pwm", pwm_out, 0);
    check("dis_pcnt", period_cnt, 0);
    check("dis_pcnt2", period_cnt2, 0);
    check("dis_pp", period_pulse, 1);
    measure("idle", 31, 0, 0, 0);
    // Asynchronous reset discards the running duty and the pending config
    offer(9, 1'b1);
    goto(0);
    tick();
    check("re_active", active, 1);
    check("re_pwm", pwm_out, 1);
    goto(4);
    offer(4, 1'b1);
    goto(8);
    #2 rst = 1'b0;
    #1 check_zero("midrst");
    repeat (2) tick();
    #2 rst = 1'b1;
    goto(0);
    tick();
    check("post_rst_active", active, 0);
    check("post_rst_pp", period_pulse, 1);
    measure("post_rst", 32, 0, 0, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
